// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining N show-ahead FIFOs into one valid/ready output register,
// with a per-grant burst quantum. Define FIFO_RR_ARB_ASSERT_EN to compile in protocol checks.

`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef ARB_QWID
`define ARB_QWID 4
`endif

module fifo_rr_arbiter #(
    parameter int N     = 2,
    parameter int WIDTH = `FIFO_DWIDTH,
    parameter int QWID  = `ARB_QWID
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       empty,
    input  logic [N*WIDTH-1:0] fifo_data,
    input  logic [QWID-1:0]    quantum,
    input  logic               out_ready,
    output logic [N-1:0]       pop,
    output logic [N-1:0]       grant,
    output logic               out_vld,
    output logic [WIDTH-1:0]   out_data
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    sel, sel_nxt;
    logic [PW-1:0]    scan_idx;
    logic [QWID-1:0]  cnt, cnt_nxt;
    logic [QWID-1:0]  q_eff;
    logic [N-1:0]     grant_nxt;
    logic             any_req;
    logic             do_pop;
    logic             release_g;
    logic             out_vld_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic [WIDTH-1:0] head;
    int               idx;

    assign any_req = !(&empty);
    assign q_eff   = (quantum == '0) ? QWID'(1) : quantum;
    assign head    = fifo_data[int'(sel)*WIDTH +: WIDTH];

    // Scan downward so the lowest offset from ptr is the last (winning) write.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        scan_idx = ptr;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (!empty[idx]) begin
                scan_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        cnt_nxt      = cnt;
        grant_nxt    = grant;
        out_vld_nxt  = out_vld;
        out_data_nxt = out_data;
        pop          = '0;
        do_pop       = 1'b0;
        release_g    = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt           = GRANT;
                    sel_nxt             = scan_idx;
                    cnt_nxt             = q_eff;
                    grant_nxt           = '0;
                    grant_nxt[scan_idx] = 1'b1;
                end
            end
            GRANT: begin
                do_pop    = !empty[sel] && (!out_vld || out_ready);
                pop[sel]  = do_pop;
                release_g = (do_pop && cnt == QWID'(1)) || (empty[sel] && !do_pop);
                if (do_pop) begin
                    cnt_nxt = cnt - 1'b1;
                end
                if (release_g) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        // A pop reloads the register even when the old word leaves this cycle: no bubble.
        if (do_pop) begin
            out_vld_nxt  = 1'b1;
            out_data_nxt = head;
        end else if (out_vld && out_ready) begin
            out_vld_nxt = 1'b0;
        end

        if (rst) begin
            pop = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            cnt      <= '0;
            grant    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            cnt      <= cnt_nxt;
            grant    <= grant_nxt;
            out_vld  <= out_vld_nxt;
            out_data <= out_data_nxt;
        end
    end

`ifdef FIFO_RR_ARB_ASSERT_EN
    logic [QWID-1:0] q_at_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_at_grant <= '0;
        end else if (state == IDLE && any_req) begin
            q_at_grant <= q_eff;
        end
    end

    a_pop_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(pop));
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_pop_legal: assert property (@(posedge clk) disable iff (rst)
        (pop & (empty | ~grant)) == '0);
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_vld && !out_ready) |=> ($stable(out_data) && $stable(out_vld)));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (state == GRANT) |-> (cnt <= q_at_grant));

    always @(posedge clk) begin
        if (rst) begin
            a_rst_hold: assert (state == IDLE && cnt == '0 && grant == '0 && !out_vld && pop == '0);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (N=2, WIDTH=8, QWID=4) with queue-modelled show-ahead FIFOs.

module tb_fifo_rr_arbiter;

    localparam int N     = 2;
    localparam int WIDTH = 8;
    localparam int QWID  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         empty;
    logic [N*WIDTH-1:0]   fifo_data;
    logic [QWID-1:0]      quantum;
    logic                 out_ready;
    logic [N-1:0]         pop;
    logic [N-1:0]         grant;
    logic                 out_vld;
    logic [WIDTH-1:0]     out_data;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.N(N), .WIDTH(WIDTH), .QWID(QWID)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .fifo_data (fifo_data),
        .quantum   (quantum),
        .out_ready (out_ready),
        .pop       (pop),
        .grant     (grant),
        .out_vld   (out_vld),
        .out_data  (out_data)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    logic [1:0] tg[$];
    logic [1:0] tp[$];
    logic       tr[$];

    int total = 0;
    int bad   = 0;

    logic [1:0] s_pop, s_grant, s_empty;
    logic       s_vld, s_rdy;
    logic [7:0] s_data;
    logic       p_vld = 1'b0;
    logic       p_rdy = 1'b1;
    logic [7:0] p_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        empty[0] = (q0.size() == 0);
        empty[1] = (q1.size() == 0);
        fifo_data = '0;
        if (q0.size() != 0) fifo_data[7:0] = q0[0];
        if (q1.size() != 0) fifo_data[15:8] = q1[0];
    endtask

    // Sample at negedge+1, let the edge happen, then retire popped/accepted words.
    task automatic cycle();
        @(negedge clk);
        #1;
        s_pop   = pop;
        s_grant = grant;
        s_vld   = out_vld;
        s_data  = out_data;
        s_empty = empty;
        s_rdy   = out_ready;
        check("pop_on_empty", 32'(s_pop & s_empty), 32'd0);
        check("pop_outside_grant", 32'(s_pop & ~s_grant), 32'd0);
        if (p_vld && !p_rdy) begin
            check("hold_vld", 32'(s_vld), 32'd1);
            check("hold_data", 32'(s_data), 32'(p_data));
        end
        p_vld  = s_vld;
        p_rdy  = s_rdy;
        p_data = s_data;
        @(posedge clk);
        #1;
        if (s_vld && s_rdy) rx.push_back(s_data);
        if (s_pop[0]) void'(q0.pop_front());
        if (s_pop[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tg.size(); i++) begin
            out_ready = (i < tr.size()) ? tr[i] : 1'b1;
            cycle();
            check({tag, "_grant"}, 32'(s_grant), 32'(tg[i]));
            check({tag, "_pop"}, 32'(s_pop), 32'(tp[i]));
        end
        out_ready = 1'b1;
        tr.delete();
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            check({tag, "_word"}, 32'(rx[i]), 32'(exp_q[i]));
        end
    endtask

    // Leaves reset released at posedge+1 with the DUT idle and nothing queued.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        rx.delete();
        drive();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        p_vld = 1'b0;
        p_rdy = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        quantum   = 4'd0;
        drive();
        #2;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_pop", 32'(pop), 32'd0);
        check("reset_vld", 32'(out_vld), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);

        // Fairness with quantum 2.
        do_reset();
        quantum = 4'd2;
        q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        drive();
        tg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
               2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        tp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00,
               2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        run_table("fair");
        exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3, 8'hA4, 8'hB4};
        check_stream("fair");

        // Single requester on FIFO1, quantum 3, pointer wraps back to it.
        do_reset();
        quantum = 4'd3;
        q1 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        drive();
        tg = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        tp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        run_table("single");
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        check_stream("single");

        // Backpressure for 4 cycles after the first word; quantum 2 shows cnt was frozen.
        do_reset();
        quantum = 4'd2;
        q0 = '{8'h70, 8'h71, 8'h72};
        drive();
        tr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        tp = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        run_table("bp");
        exp_q = '{8'h70, 8'h71, 8'h72};
        check_stream("bp");

        // Zero quantum behaves as one pop per grant.
        do_reset();
        quantum = 4'd0;
        q0 = '{8'h30, 8'h31};
        q1 = '{8'h40, 8'h41};
        drive();
        tg = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        tp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        run_table("zeroq");
        exp_q = '{8'h30, 8'h40, 8'h31, 8'h41};
        check_stream("zeroq");

        // Early empty release with quantum 4.
        do_reset();
        quantum = 4'd4;
        q0 = '{8'h50, 8'h51};
        q1 = '{8'h60};
        drive();
        tg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        tp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        run_table("early");
        exp_q = '{8'h50, 8'h51, 8'h60};
        check_stream("early");

        // Reset mid-burst while FIFO1 holds the grant with a word pending.
        do_reset();
        quantum = 4'd2;
        q0 = '{8'h10, 8'h11, 8'h12};
        q1 = '{8'h20, 8'h21, 8'h22};
        drive();
        tg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        tp = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        run_table("prerst");
        exp_q = '{8'h10, 8'h11};
        check_stream("prerst");
        @(negedge clk);
        #1;
        check("midrst_grant_before", 32'(grant), 32'h2);
        check("midrst_pop_before", 32'(pop), 32'h2);
        check("midrst_vld_before", 32'(out_vld), 32'd1);
        check("midrst_data_before", 32'(out_data), 32'h20);
        rst = 1'b1;
        #1;
        check("midrst_pop_async", 32'(pop), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_vld_after", 32'(out_vld), 32'd0);
        check("midrst_grant_after", 32'(grant), 32'd0);
        check("midrst_data_after", 32'(out_data), 32'd0);
        rst   = 1'b0;
        p_vld = 1'b0;
        p_rdy = 1'b1;
        rx.delete();
        drive();
        tg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        tp = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        run_table("postrst");
        exp_q = '{8'h12, 8'h21, 8'h22};
        check_stream("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter sharing one output channel among `N` show-ahead `fifo` instances. It watches each FIFO's `empty` and drives one-hot `pop` strobes, with a per-grant burst quantum of up to `quantum` pops. Popped words land in a single-entry output register with a valid/ready handshake. It sits between the per-requester FIFOs and the downstream consumer/scoreboard in the composed designs.

## Interface
- `N`, 2, number of requester FIFOs (≥2)
- `WIDTH`, `` `FIFO_DWIDTH ``, data width
- `QWID`, `` `ARB_QWID ``, width of quantum and burst counter
- `clk`  in  1  clock, all state on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `empty`  in  N  per-FIFO empty flags
- `fifo_data`  in  N*WIDTH  per-FIFO head word; slice i = `[i*WIDTH +: WIDTH]`; valid whenever `!empty[i]`
- `quantum`  in  QWID  max pops per grant; 0 is treated as 1
- `out_ready`  in  1  downstream accepts `out_data` this cycle
- `pop`  out  N  one-hot-or-zero pop strobes to the FIFOs, combinational
- `grant`  out  N  one-hot-or-zero registered current grant
- `out_vld`  out  1  `out_data` holds an unconsumed word
- `out_data`  out  WIDTH  output register

## Operation
- States:
  - IDLE: `grant` = 0; no pops.
  - GRANT: one requester `sel` is held.
- Pointer `ptr` (log2 N bits, wraps N-1→0) is the highest-priority candidate.
- IDLE→GRANT when any `!empty[i]`:
  - `sel` = first non-empty index scanning `ptr, ptr+1, …` modulo N.
  - `cnt` ← max(`quantum`, 1). Quantum is sampled only here; changes mid-burst are ignored.
- In GRANT:
  - `pop[sel]` = `!empty[sel] && (!out_vld || out_ready)`.
  - Never pop an empty FIFO. Never pop more than one FIFO per cycle.
- On pop:
  - `out_data` ← `fifo_data[sel]`, `out_vld` ← 1, `cnt` ← `cnt`-1.
- Without a pop: if `out_ready && out_vld`, then `out_vld` ← 0.
- Pop and `out_ready` in the same cycle: the register reloads and `out_vld` stays 1 (no bubble).
- Release GRANT→IDLE, with `ptr` ← `sel`+1 mod N, when either:
  - a pop occurs with `cnt`==1, or
  - `empty[sel]` is 1 and no pop occurs.
- Backpressure (`out_vld && !out_ready`): no pop, `cnt` and state frozen, `out_data` stable.
- Words from one FIFO appear in FIFO order. Bursts from different FIFOs never interleave within a grant.

## Timing
- Reset (async assert, any state): `state`=IDLE, `ptr`=0, `cnt`=0, `grant`=0, `out_vld`=0, `out_data`=0. `pop`=0 while `rst` is high.
- First word latency, with `empty[i]` falling at cycle t while in IDLE:
  - `grant` at t+1
  - `pop` at t+1
  - `out_vld` at t+2
- Throughput within a burst: 1 word/cycle with `out_ready`=1.
- Each release costs exactly one IDLE bubble cycle before the next grant.
- Starvation bound: a non-empty FIFO is granted within N-1 other grants.

## Configuration
- `FIFO_RR_ARB_ASSERT_EN` defined: compiles in formal/simulation checks:
  - `pop` and `grant` are onehot0.
  - `pop[i]` implies `!empty[i]` and `grant[i]`.
  - `out_data` and `out_vld` are stable while `out_vld && !out_ready`.
  - `cnt` ≤ max(`quantum` at grant, 1).
  - No state changes while `rst` is high.
- `FIFO_RR_ARB_ASSERT_EN` undefined: no assertions. Functional behaviour is identical.

## Test plan
All cases use N=2, WIDTH=8, QWID=4.
- Reset mid-burst: assert `rst` during GRANT with `out_vld`=1 → same-cycle `pop`=0; after the edge `out_vld`=0, `grant`=0. After release, FIFO0 is granted first (`ptr`=0).
- Fairness:
  - Setup: FIFO0 holds A0..A4, FIFO1 holds B0..B4, `quantum`=2, `out_ready`=1.
  - Expected `out_data` order: A0 A1 B0 B1 A2 A3 B2 B3 A4 B4, with one idle cycle between bursts.
- Single requester: only FIFO1 non-empty, 5 words, `quantum`=3 → 3 pops, 1 IDLE cycle, re-grant FIFO1 (`ptr` wrap), then 2 pops and release on empty.
- Backpressure: hold `out_ready`=0 for 4 cycles after the first word → `pop`=0, `out_data`/`out_vld` stable, `cnt` unchanged. On `out_ready`=1, the stream resumes with no lost or duplicated words.
- Zero quantum: `quantum`=0, both FIFOs hold 2 words → alternating A0 B0 A1 B1.
- Early empty: `quantum`=4, FIFO0 holds 2 words, FIFO1 holds 1 word → A0 A1, release, then B0. `pop` never asserts on an empty FIFO.
